mmio_uart_tx: RTL and testbench

Memory-mapped serial transmitter that sits on the core's data-memory bus (we, a, wd, rd) alongside the data memory. It decodes a small register window, takes store instructions as bytes into a FIFO, and serialises them 8N1 on a single output line. The top level selects between this block's read data and data-memory read data using the sel output.

---
 rtl/mmio_uart_tx.sv | 155 +++++++++++++++
 tb/tb_mmio_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter: TXDATA/STATUS/DIVISOR window on the data bus,
// byte FIFO in front of a start/data/stop shifter with a per-frame baud divisor.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [7:0]        shift_q, shift_d;
  logic [15:0]       div_q, div_d, dlat_q, dlat_d, baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              ovf_q, ovf_d, tx_q, tx_d;

  logic [29:0] off;
  logic        hit_tx, hit_status, hit_div;
  logic        push_req, push_ok, pop, full, empty, busy, bit_end;
  logic [15:0] eff_div;
  logic [15:0] unused_wd;

  assign unused_wd = wd[31:16];

  // Word offset from the base; a[1:0] never participates in decode.
  assign off        = a[31:2] - BASE_ADDR[31:2];
  assign sel        = (off[29:2] == 28'd0) && (off[1:0] != 2'b11);
  assign hit_tx     = sel && (off[1:0] == 2'b00);
  assign hit_status = sel && (off[1:0] == 2'b01);
  assign hit_div    = sel && (off[1:0] == 2'b10);

  assign full     = (count_q == CntW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != StIdle);
  assign pop      = (state_q == StIdle) && !empty;
  assign push_req = we && hit_tx;
  // A same-cycle pop frees a slot, so a push on full is still accepted.
  assign push_ok  = push_req && (!full || pop);
  assign eff_div  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign bit_end  = (baud_q == dlat_q - 16'd1);

  assign tx  = tx_q;
  assign irq = empty && !busy;

  always_comb begin
    rd = 32'd0;
    if (hit_status) rd = {24'd0, 4'(count_q), ovf_q, busy, empty, full};
    else if (hit_div) rd = {16'd0, div_q};
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (we && hit_status) ovf_d = 1'b0;
    else if (push_req && !push_ok) ovf_d = 1'b1;
    div_d = (we && hit_div) ? wd[15:0] : div_q;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    dlat_d  = dlat_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = fifo_q[rd_ptr_q];
          dlat_d  = eff_div;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          state_d = StStart;
        end
      end
      StStart: begin
        baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        if (bit_end) state_d = StData;
      end
      StData: begin
        baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
        if (bit_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Line level follows the state one cycle later.
    case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_q[bit_q];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= 8'd0;
      div_q    <= DEFAULT_DIV;
      dlat_q   <= 16'd1;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      ovf_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      div_q    <= div_d;
      dlat_q   <= dlat_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      ovf_q    <= ovf_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, exact serial timing, FIFO overflow,
// pointer wrap, divisor edge cases and mid-frame reset.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam logic [31:0] Base = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a, wd, rd;
  logic        sel, tx, irq;

  int n_checks = 0;
  int n_errs   = 0;
  int rx_div   = 16;
  bit rx_en    = 1'b0;
  logic [7:0] rx_q [$];

  mmio_uart_tx dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .a     (a),
    .wd    (wd),
    .rd    (rd),
    .sel   (sel),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    we = 1'b0; a = addr;
    #1 data = rd;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("rx_count", rx_q.size(), n);
  endtask

  task automatic pop_rx(input string tag, input logic [7:0] exp);
    logic [7:0] got;
    if (rx_q.size() == 0) got = 8'hxx;
    else got = rx_q.pop_front();
    check(tag, {24'd0, got}, {24'd0, exp});
  endtask

  // Line receiver: samples the first cycle of every bit after the falling start edge.
  initial begin : rx_mon
    logic [7:0] b;
    int         d;
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) begin
        d = rx_div;
        for (int i = 0; i < 8; i++) begin
          repeat (d) @(negedge clk);
          b[i] = tx;
        end
        repeat (d) @(negedge clk);
        if (rx_en) begin
          check("rx_stop", {31'd0, tx}, 32'd1);
          rx_q.push_back(b);
        end
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog timeout got=hang exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] r;
    logic [9:0]  seq;
    logic [7:0]  wb;

    reset = 1'b0; we = 1'b0; a = 32'd0; wd = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd1);
    bus_rd(Base + 4, r);  check("rst_status", r, 32'h02);
    bus_rd(Base + 8, r);  check("rst_div", r, 32'h10);

    // Single byte at D=4 with cycle-exact line check.
    rx_div = 4; rx_en = 1'b1;
    bus_wr(Base + 8, 32'h0000_0004);
    bus_rd(Base + 8, r); check("div_rb", r, 32'h4);
    bus_wr(Base, 32'h1234_56A5);
    seq = {1'b1, 8'hA5, 1'b0};
    @(negedge clk); check("lat_n0", {31'd0, tx}, 32'd1);
    @(negedge clk); check("lat_n1", {31'd0, tx}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check($sformatf("a5_bit%0d", i / 4), {31'd0, tx}, {31'd0, seq[i/4]});
      if (i == 20) check("a5_irq_busy", {31'd0, irq}, 32'd0);
    end
    @(negedge clk);
    check("a5_irq_done", {31'd0, irq}, 32'd1);
    wait_rx(1, 10);
    pop_rx("rx_a5", 8'hA5);

    // Fill and overflow at D=100.
    rx_div = 100;
    bus_wr(Base + 8, 32'd100);
    for (int k = 0; k < 6; k++) bus_wr(Base, 32'(8'h11 * (k + 1)));
    bus_rd(Base + 4, r); check("ovf_status", r, 32'h4D);
    bus_wr(Base + 4, 32'd0);
    bus_rd(Base + 4, r); check("ovf_clear", r, 32'h45);
    wait_rx(5, 6000);
    for (int k = 0; k < 5; k++) pop_rx($sformatf("rx_fill%0d", k), 8'(8'h11 * (k + 1)));
    repeat (110) @(negedge clk);
    check("fill_drop", rx_q.size(), 0);
    bus_rd(Base + 4, r); check("fill_idle", r, 32'h02);

    // Pointer wrap: ten bytes paced so the FIFO never fills.
    rx_div = 2;
    bus_wr(Base + 8, 32'd2);
    for (int k = 0; k < 10; k++) begin
      wb = 8'(k * 29 + 7);
      bus_wr(Base, {24'd0, wb});
      repeat (15) @(negedge clk);
    end
    wait_rx(10, 400);
    for (int k = 0; k < 10; k++) pop_rx($sformatf("rx_wrap%0d", k), 8'(k * 29 + 7));
    repeat (10) @(negedge clk);
    bus_rd(Base + 4, r); check("wrap_status", r, 32'h02);

    // Divisor 0 acts as 1; a mid-frame divisor write applies to the next frame.
    rx_div = 1;
    bus_wr(Base + 8, 32'd0);
    bus_wr(Base, 32'h0F);
    repeat (2) @(negedge clk);
    bus_wr(Base + 8, 32'd8);
    rx_div = 8;
    bus_wr(Base, 32'hC3);
    bus_rd(Base + 8, r); check("div8_rb", r, 32'h8);
    wait_rx(2, 200);
    pop_rx("rx_div1", 8'h0F);
    pop_rx("rx_div8", 8'hC3);
    repeat (10) @(negedge clk);

    // Decode.
    bus_rd(Base + 12, r); check("rd_off12", r, 32'h0);
    bus_rd(Base + 32'h20, r);
    check("rd_out", r, 32'h0);
    check("sel_out", {31'd0, sel}, 32'd0);
    bus_rd(Base, r);
    check("rd_txdata", r, 32'h0);
    check("sel_in", {31'd0, sel}, 32'd1);
    bus_wr(Base + 12, 32'h55);
    bus_rd(Base + 8, r); check("off12_wr_div", r, 32'h8);
    bus_rd(Base + 4, r); check("off12_wr_stat", r, 32'h02);

    // Reset during DATA.
    rx_en = 1'b0;
    bus_wr(Base, 32'h00);
    bus_wr(Base, 32'h5A);
    bus_wr(Base, 32'h5A);
    repeat (12) @(negedge clk);
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_mid_tx", {31'd0, tx}, 32'd1);
    check("rst_mid_irq", {31'd0, irq}, 32'd1);
    bus_rd(Base + 4, r); check("rst_mid_status", r, 32'h02);
    bus_rd(Base + 8, r); check("rst_mid_div", r, 32'h10);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) check("post_rst_idle", {31'd0, tx}, 32'd1);
    end
    bus_rd(Base + 4, r); check("post_rst_status", r, 32'h02);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
